// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one outstanding imem request, loads IF/ID.
// 1 instr/cycle with gnt=1 and 1-cycle response; StallD parks one response in a skid, redirect flushes.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        StallD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_req_pc;
  logic        r_drop;
  fetch_t      r_skid;
  ifid_t       r_ifid;

  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_req_pc_nxt;
  logic        w_drop_nxt;
  fetch_t      w_skid_nxt;
  ifid_t       w_ifid_nxt;
  logic        w_req;
  logic        w_redirect;
  logic        w_deliver;
  fetch_t      w_dlv;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_req_pc <= 32'h0;
      r_drop   <= 1'b0;
      r_skid   <= '0;
      r_ifid   <= '{instr: BUBBLE_INSTR, pc: 32'h0, pc4: 32'h0, valid: 1'b0};
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_req_pc <= w_req_pc_nxt;
      r_drop   <= w_drop_nxt;
      r_skid   <= w_skid_nxt;
      r_ifid   <= w_ifid_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_req_pc_nxt = r_req_pc;
    w_drop_nxt   = r_drop;
    w_skid_nxt   = r_skid;
    w_ifid_nxt   = r_ifid;
    w_req        = 1'b0;
    w_deliver    = 1'b0;
    w_dlv        = r_skid;
    w_redirect   = PCSrcE && (r_state != S_IDLE);

    case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ: begin
        w_req = !PCSrcE;
        if (w_req && imem_gnt) begin
          w_req_pc_nxt = r_pc;
          w_pc_nxt     = r_pc + 32'd4;
          w_state_nxt  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          w_drop_nxt = 1'b0;
          if (r_drop || PCSrcE) begin
            w_state_nxt = S_REQ;
          end else if (StallD) begin
            w_skid_nxt  = '{instr: imem_rdata, pc: r_req_pc};
            w_state_nxt = S_HOLD;
          end else begin
            // Response consumed this cycle, so the next request may overlap it.
            w_deliver = 1'b1;
            w_dlv     = '{instr: imem_rdata, pc: r_req_pc};
            w_req     = 1'b1;
            if (imem_gnt) begin
              w_req_pc_nxt = r_pc;
              w_pc_nxt     = r_pc + 32'd4;
            end else begin
              w_state_nxt = S_REQ;
            end
          end
        end else if (PCSrcE) begin
          w_drop_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (PCSrcE) begin
          w_state_nxt = S_REQ;
        end else if (!StallD) begin
          w_deliver   = 1'b1;
          w_dlv       = r_skid;
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_redirect) w_pc_nxt = PCTargetE;

    // Redirect flush beats StallD; PCD/PCPlus4D keep their last values on bubbles.
    if (w_redirect) begin
      w_ifid_nxt.valid = 1'b0;
      w_ifid_nxt.instr = BUBBLE_INSTR;
    end else if (!StallD) begin
      if (w_deliver) begin
        w_ifid_nxt = '{instr: w_dlv.instr, pc: w_dlv.pc, pc4: w_dlv.pc + 32'd4, valid: 1'b1};
      end else begin
        w_ifid_nxt.valid = 1'b0;
        w_ifid_nxt.instr = BUBBLE_INSTR;
      end
    end
  end

  assign imem_req  = w_req;
  assign imem_addr = r_pc;
  assign InstrD    = r_ifid.instr;
  assign PCD       = r_ifid.pc;
  assign PCPlus4D  = r_ifid.pc4;
  assign ValidD    = r_ifid.valid;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl against a transaction-level model of outstanding/parked fetches.
module tb_fetch_ctrl;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] BUBBLE   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        StallD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;

  fetch_ctrl #(.RESET_PC(RESET_PC), .BUBBLE_INSTR(BUBBLE)) dut (
    .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallD(StallD),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: fetch address, at most one request in flight, at most one parked response.
  logic        m_started;
  logic [31:0] m_pc;
  logic        m_infl;
  logic        m_stale;
  logic [31:0] m_infl_pc;
  logic        m_parked;
  logic [31:0] m_park_instr;
  logic [31:0] m_park_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pcd;
  logic [31:0] m_pc4;
  logic        m_valid;

  // Memory responder
  logic        mem_busy = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_data = 32'h0;
  int          lat_fix  = 1;
  logic        spur_en  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_started = 1'b0;  m_pc = RESET_PC;
    m_infl = 1'b0;     m_stale = 1'b0;  m_infl_pc = 32'h0;
    m_parked = 1'b0;   m_park_instr = 32'h0; m_park_pc = 32'h0;
    m_instr = BUBBLE;  m_pcd = 32'h0;   m_pc4 = 32'h0;  m_valid = 1'b0;
  endtask

  task automatic cycle(input logic pcs, input logic [31:0] tgt, input logic stl, input logic g);
    logic fire, resp, cons, ereq, redir;
    @(negedge clk);
    PCSrcE = pcs; PCTargetE = tgt; StallD = stl; imem_gnt = g;
    fire = 1'b0;
    if (mem_busy) begin
      mem_cnt--;
      fire = (mem_cnt == 0);
    end
    if (fire) begin
      imem_rvalid = 1'b1; imem_rdata = mem_data;
    end else if (spur_en && !mem_busy && $urandom_range(3) == 0) begin
      imem_rvalid = 1'b1; imem_rdata = $urandom;
    end else begin
      imem_rvalid = 1'b0; imem_rdata = $urandom;
    end
    #1;
    redir = m_started && pcs;
    resp  = m_infl && imem_rvalid;
    cons  = resp && !m_stale && !pcs && !stl;
    ereq  = m_started && !pcs && ((!m_infl && !m_parked) || cons);

    chk("imem_req",  imem_req,  ereq);
    chk("imem_addr", imem_addr, m_pc);
    chk("InstrD",    InstrD,    m_instr);
    chk("PCD",       PCD,       m_pcd);
    chk("PCPlus4D",  PCPlus4D,  m_pc4);
    chk("ValidD",    ValidD,    m_valid);

    if (redir) begin
      m_valid = 1'b0; m_instr = BUBBLE;
    end else if (!stl) begin
      if (cons) begin
        m_instr = imem_rdata; m_pcd = m_infl_pc; m_pc4 = m_infl_pc + 32'd4; m_valid = 1'b1;
      end else if (m_parked) begin
        m_instr = m_park_instr; m_pcd = m_park_pc; m_pc4 = m_park_pc + 32'd4; m_valid = 1'b1;
      end else begin
        m_valid = 1'b0; m_instr = BUBBLE;
      end
    end
    if (m_parked && (pcs || !stl)) m_parked = 1'b0;
    if (resp && !m_stale && !pcs && stl) begin
      m_parked = 1'b1; m_park_instr = imem_rdata; m_park_pc = m_infl_pc;
    end
    if (resp) m_infl = 1'b0;
    else if (m_infl && pcs) m_stale = 1'b1;
    if (ereq && g) begin
      m_infl = 1'b1; m_stale = 1'b0; m_infl_pc = m_pc;
    end
    if (redir) m_pc = tgt;
    else if (ereq && g) m_pc = m_pc + 32'd4;
    m_started = 1'b1;

    if (fire) mem_busy = 1'b0;
    if (imem_req && imem_gnt) begin
      mem_busy = 1'b1;
      mem_cnt  = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 3));
      mem_data = $urandom;
    end
  endtask

  // Async reset in the middle of a cycle; outputs must clear without a clock edge.
  task automatic mid_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_req",    imem_req,  1'b0);
    chk("rst_addr",   imem_addr, RESET_PC);
    chk("rst_InstrD", InstrD,    BUBBLE);
    chk("rst_PCD",    PCD,       32'h0);
    chk("rst_PC4",    PCPlus4D,  32'h0);
    chk("rst_ValidD", ValidD,    1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    // Late responses from before the reset arrive while grants are withheld.
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] tgt;
    rst = 1'b1; PCSrcE = 1'b0; PCTargetE = 32'h0; StallD = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    #2 rst = 1'b0;
    #1;
    chk("init_req",    imem_req,  1'b0);
    chk("init_addr",   imem_addr, RESET_PC);
    chk("init_InstrD", InstrD,    BUBBLE);
    chk("init_ValidD", ValidD,    1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    // Streaming with 1-cycle latency
    lat_fix = 1;
    for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1);
    // Grant withheld for 3 cycles
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1);
    // Redirect while waiting on a 3-cycle response
    lat_fix = 3;
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b1, 32'h100, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1);
    // Decode stall across a response, then redirect under stall
    lat_fix = 1;
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    cycle(1'b1, 32'h400, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1);
    // Reset while a request is outstanding
    lat_fix = 3;
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    mid_reset();
    // PC wrap at the top of the address space
    lat_fix = 1;
    cycle(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1);

    // Randomized traffic with spurious rvalid while nothing is outstanding
    lat_fix = 0;
    spur_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tgt = {$urandom} & 32'hFFFF_FFFC;
      if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFF0 | ({$urandom} & 32'hC);
      cycle($urandom_range(7) == 0, tgt, $urandom_range(3) == 0, $urandom_range(3) != 0);
      if (i == 1500) mid_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
